// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: captures the fetched instruction and PC, adds flush,
// valid, branch-delay-slot tagging, fetch-address fault detection and a stall counter.
module if_id_pipe_reg #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_3000,
    parameter logic [XLEN-1:0] IMEM_BASE = 32'h0000_3000,
    parameter logic [XLEN-1:0] IMEM_SIZE = 32'h0000_1000,
    parameter logic [XLEN-1:0] NOP_WORD  = 32'h0000_0000,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  instr,
    input  logic [XLEN-1:0]  pc,
    input  logic             stall,
    input  logic             flush,
    input  logic             d_is_branch,
    output logic [XLEN-1:0]  ir_d,
    output logic [XLEN-1:0]  pc_d,
    output logic [XLEN-1:0]  pc4_d,
    output logic [XLEN-1:0]  pc8_d,
    output logic             valid_d,
    output logic             bd_d,
    output logic [4:0]       exc_d,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    // One extra bit so a window ending at the top of the address space cannot overflow.
    localparam logic [XLEN:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

    logic [XLEN-1:0]  ir_q,    ir_d_n;
    logic [XLEN-1:0]  pc_q,    pc_d_n;
    logic [XLEN-1:0]  pc4_q,   pc4_d_n;
    logic [XLEN-1:0]  pc8_q,   pc8_d_n;
    logic             valid_q, valid_d_n;
    logic             bd_q,    bd_d_n;
    logic [4:0]       exc_q,   exc_d_n;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic            fetch_fault;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus8;

    assign fetch_fault = (pc[1:0] != 2'b00)
                      || (pc < IMEM_BASE)
                      || ({1'b0, pc} >= IMEM_LIMIT);
    assign pc_plus4    = pc + XLEN'(4);
    assign pc_plus8    = pc + XLEN'(8);

    always_comb begin
        ir_d_n    = ir_q;
        pc_d_n    = pc_q;
        pc4_d_n   = pc4_q;
        pc8_d_n   = pc8_q;
        valid_d_n = valid_q;
        bd_d_n    = bd_q;
        exc_d_n   = exc_q;
        cnt_d     = cnt_q;
        if (flush) begin
            // PC fields keep tracking the fetch so the EPC source stays current.
            ir_d_n    = NOP_WORD;
            pc_d_n    = pc;
            pc4_d_n   = pc_plus4;
            pc8_d_n   = pc_plus8;
            valid_d_n = 1'b0;
            bd_d_n    = 1'b0;
            exc_d_n   = EXC_NONE;
        end else if (stall) begin
            if (valid_q && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            pc_d_n    = pc;
            pc4_d_n   = pc_plus4;
            pc8_d_n   = pc_plus8;
            valid_d_n = 1'b1;
            bd_d_n    = d_is_branch & valid_q;
            if (fetch_fault) begin
                ir_d_n  = NOP_WORD;
                exc_d_n = EXC_ADEL;
            end else begin
                ir_d_n  = instr;
                exc_d_n = EXC_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q    <= NOP_WORD;
            pc_q    <= RESET_PC;
            pc4_q   <= RESET_PC + XLEN'(4);
            pc8_q   <= RESET_PC + XLEN'(8);
            valid_q <= 1'b0;
            bd_q    <= 1'b0;
            exc_q   <= EXC_NONE;
            cnt_q   <= '0;
        end else begin
            ir_q    <= ir_d_n;
            pc_q    <= pc_d_n;
            pc4_q   <= pc4_d_n;
            pc8_q   <= pc8_d_n;
            valid_q <= valid_d_n;
            bd_q    <= bd_d_n;
            exc_q   <= exc_d_n;
            cnt_q   <= cnt_d;
        end
    end

    assign ir_d      = ir_q;
    assign pc_d      = pc_q;
    assign pc4_d     = pc4_q;
    assign pc8_d     = pc8_q;
    assign valid_d   = valid_q;
    assign bd_d      = bd_q;
    assign exc_d     = exc_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg: default instance plus a CNT_W=2 instance
// driven identically to exercise stall-counter saturation.
module tb_if_id_pipe_reg;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic        valid;
        logic        bd;
        logic [4:0]  exc;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        d_is_branch;

    logic [31:0] ir_d, pc_d, pc4_d, pc8_d;
    logic        valid_d, bd_d;
    logic [4:0]  exc_d;
    logic [15:0] stall_cnt;

    logic [31:0] ir_d2, pc_d2, pc4_d2, pc8_d2;
    logic        valid_d2, bd_d2;
    logic [4:0]  exc_d2;
    logic [1:0]  stall_cnt2;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    event  chk_now;

    if_id_pipe_reg dut (
        .clk(clk), .reset(reset), .instr(instr), .pc(pc), .stall(stall),
        .flush(flush), .d_is_branch(d_is_branch),
        .ir_d(ir_d), .pc_d(pc_d), .pc4_d(pc4_d), .pc8_d(pc8_d),
        .valid_d(valid_d), .bd_d(bd_d), .exc_d(exc_d), .stall_cnt(stall_cnt)
    );

    if_id_pipe_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .instr(instr), .pc(pc), .stall(stall),
        .flush(flush), .d_is_branch(d_is_branch),
        .ir_d(ir_d2), .pc_d(pc_d2), .pc4_d(pc4_d2), .pc8_d(pc8_d2),
        .valid_d(valid_d2), .bd_d(bd_d2), .exc_d(exc_d2), .stall_cnt(stall_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s.%s got=%h expected=%h", nm, fld, got, want);
        end
    endtask

    // Monitor: the register presents fresh outputs every cycle; sample at negedge
    // or on demand for the asynchronous-reset check.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk or chk_now);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, "ir_d",      ir_d,             e.ir);
                chk(nm, "pc_d",      pc_d,             e.pc);
                chk(nm, "pc4_d",     pc4_d,            e.pc4);
                chk(nm, "pc8_d",     pc8_d,            e.pc8);
                chk(nm, "valid_d",   {31'd0, valid_d}, {31'd0, e.valid});
                chk(nm, "bd_d",      {31'd0, bd_d},    {31'd0, e.bd});
                chk(nm, "exc_d",     {27'd0, exc_d},   {27'd0, e.exc});
                chk(nm, "stall_cnt", {16'd0, stall_cnt}, {16'd0, e.cnt});
                chk(nm, "w2.ir_d",   ir_d2,            e.ir);
                chk(nm, "w2.pc_d",   pc_d2,            e.pc);
                chk(nm, "w2.pc4_d",  pc4_d2,           e.pc4);
                chk(nm, "w2.pc8_d",  pc8_d2,           e.pc8);
                chk(nm, "w2.valid",  {31'd0, valid_d2}, {31'd0, e.valid});
                chk(nm, "w2.bd",     {31'd0, bd_d2},   {31'd0, e.bd});
                chk(nm, "w2.exc",    {27'd0, exc_d2},  {27'd0, e.exc});
                chk(nm, "w2.stall_cnt", {30'd0, stall_cnt2}, {30'd0, e.cnt2});
            end
        end
    end

    task automatic expect_state(input string nm, input logic [31:0] e_ir,
                                input logic [31:0] e_pc, input logic e_v,
                                input logic e_bd, input logic [4:0] e_exc,
                                input logic [15:0] e_cnt, input logic [1:0] e_cnt2);
        exp_t e;
        e.ir    = e_ir;
        e.pc    = e_pc;
        e.pc4   = e_pc + 32'd4;
        e.pc8   = e_pc + 32'd8;
        e.valid = e_v;
        e.bd    = e_bd;
        e.exc   = e_exc;
        e.cnt   = e_cnt;
        e.cnt2  = e_cnt2;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input string nm, input logic [31:0] pc_v, input logic [31:0] in_v,
                        input logic st, input logic fl, input logic br,
                        input logic [31:0] e_ir, input logic [31:0] e_pc,
                        input logic e_v, input logic e_bd, input logic [4:0] e_exc,
                        input logic [15:0] e_cnt, input logic [1:0] e_cnt2);
        pc          = pc_v;
        instr       = in_v;
        stall       = st;
        flush       = fl;
        d_is_branch = br;
        @(posedge clk);
        #1;
        expect_state(nm, e_ir, e_pc, e_v, e_bd, e_exc, e_cnt, e_cnt2);
    endtask

    initial begin
        int budget;
        reset = 1'b0; pc = 32'h0; instr = 32'h0;
        stall = 1'b0; flush = 1'b0; d_is_branch = 1'b0;
        #1;
        expect_state("reset", 32'h0, 32'h3000, 0, 0, 5'd0, 16'd0, 2'd0);
        #11 reset = 1'b1;

        //    name          pc            instr         st fl br  ir            pc            v  bd exc    cnt    cnt2
        step("first_load", 32'h3000, 32'h3C01_1234, 0, 0, 0, 32'h3C01_1234, 32'h3000, 1, 0, 5'd0, 16'd0, 2'd0);
        step("beq_load",   32'h3004, 32'h1022_0003, 0, 0, 0, 32'h1022_0003, 32'h3004, 1, 0, 5'd0, 16'd0, 2'd0);
        step("delay_slot", 32'h3008, 32'h0000_0000, 0, 0, 1, 32'h0000_0000, 32'h3008, 1, 1, 5'd0, 16'd0, 2'd0);
        step("after_slot", 32'h300C, 32'hAC01_0000, 0, 0, 0, 32'hAC01_0000, 32'h300C, 1, 0, 5'd0, 16'd0, 2'd0);
        step("stall1",     32'h3010, 32'h1234_5678, 1, 0, 1, 32'hAC01_0000, 32'h300C, 1, 0, 5'd0, 16'd1, 2'd1);
        step("stall2",     32'h3010, 32'h1234_5678, 1, 0, 0, 32'hAC01_0000, 32'h300C, 1, 0, 5'd0, 16'd2, 2'd2);
        step("stall3",     32'h3010, 32'h1234_5678, 1, 0, 0, 32'hAC01_0000, 32'h300C, 1, 0, 5'd0, 16'd3, 2'd3);
        step("stall4_sat", 32'h3010, 32'h1234_5678, 1, 0, 0, 32'hAC01_0000, 32'h300C, 1, 0, 5'd0, 16'd4, 2'd3);
        step("stall5_sat", 32'h3010, 32'h1234_5678, 1, 0, 0, 32'hAC01_0000, 32'h300C, 1, 0, 5'd0, 16'd5, 2'd3);
        step("flush_stall",32'h3010, 32'h1234_5678, 1, 1, 1, 32'h0000_0000, 32'h3010, 0, 0, 5'd0, 16'd5, 2'd3);
        step("stall_inval",32'h3014, 32'h1234_5678, 1, 0, 0, 32'h0000_0000, 32'h3010, 0, 0, 5'd0, 16'd5, 2'd3);
        step("misaligned", 32'h3002, 32'hDEAD_BEEF, 0, 0, 1, 32'h0000_0000, 32'h3002, 1, 0, 5'd4, 16'd5, 2'd3);
        step("above_win",  32'h4000, 32'h1111_1111, 0, 0, 0, 32'h0000_0000, 32'h4000, 1, 0, 5'd4, 16'd5, 2'd3);
        step("last_word",  32'h3FFC, 32'h2222_2222, 0, 0, 0, 32'h2222_2222, 32'h3FFC, 1, 0, 5'd0, 16'd5, 2'd3);
        step("below_win",  32'h2FFC, 32'h3333_3333, 0, 0, 0, 32'h0000_0000, 32'h2FFC, 1, 0, 5'd4, 16'd5, 2'd3);
        step("pc_wrap",    32'hFFFF_FFFC, 32'h4444_4444, 0, 0, 0, 32'h0000_0000, 32'hFFFF_FFFC, 1, 0, 5'd4, 16'd5, 2'd3);
        step("bd_valid",   32'h3020, 32'h5555_5555, 0, 0, 1, 32'h5555_5555, 32'h3020, 1, 1, 5'd0, 16'd5, 2'd3);
        step("stall6",     32'h3024, 32'h6666_6666, 1, 0, 0, 32'h5555_5555, 32'h3020, 1, 1, 5'd0, 16'd6, 2'd3);
        step("stall7",     32'h3024, 32'h6666_6666, 1, 0, 0, 32'h5555_5555, 32'h3020, 1, 1, 5'd0, 16'd7, 2'd3);

        // Reset pulled low between edges while still stalled.
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        expect_state("async_reset", 32'h0, 32'h3000, 0, 0, 5'd0, 16'd0, 2'd0);
        -> chk_now;
        #1 reset = 1'b1;

        step("post_rst_stall", 32'h3000, 32'h3C01_1234, 1, 0, 0, 32'h0000_0000, 32'h3000, 0, 0, 5'd0, 16'd0, 2'd0);
        step("post_rst_load",  32'h3000, 32'h3C01_1234, 0, 0, 1, 32'h3C01_1234, 32'h3000, 1, 0, 5'd0, 16'd0, 2'd0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Parametrised IF/ID pipeline register for the five-stage MIPS pipeline; sits between the fetch stage (PC, IM) and the decode stage.
- Captures the fetched instruction and PC and generates PC+4 and PC+8.
- Beyond a plain latch it adds flush, a valid bit, branch-delay-slot tagging, fetch-address exception detection and a saturating stall-cycle counter.

Parameters:
- XLEN, 32, datapath width of the instruction and PC.
- RESET_PC, 32'h0000_3000, PC value held after reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_SIZE, 32'h0000_1000, legal fetch window size in bytes.
- NOP_WORD, 32'h0000_0000, instruction word used for bubbles and faulting fetches.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low (0 = reset).
- instr  input  XLEN  instruction word from IM for the current fetch PC.
- pc  input  XLEN  current fetch PC.
- stall  input  1  hazard unit hold of the D stage.
- flush  input  1  discard D-stage content (exception / eret).
- d_is_branch  input  1  decoder flag: the instruction currently in D is a branch or jump.
- ir_d  output  XLEN  instruction in D.
- pc_d  output  XLEN  PC of the instruction in D.
- pc4_d  output  XLEN  pc_d + 4.
- pc8_d  output  XLEN  pc_d + 8.
- valid_d  output  1  D holds a real instruction.
- bd_d  output  1  instruction in D sits in a branch delay slot.
- exc_d  output  5  ExcCode of the fetch: 0 = none, 4 = AdEL.
- stall_cnt  output  CNT_W  number of cycles stalled with valid_d = 1.

Behaviour:
- Reset (reset = 0, asynchronous, takes effect immediately):
  - ir_d = NOP_WORD; pc_d = RESET_PC; pc4_d = RESET_PC + 4; pc8_d = RESET_PC + 8.
  - valid_d = 0; bd_d = 0; exc_d = 0; stall_cnt = 0.
- Release: the first posedge with reset = 1 performs a normal update. A reset asserted mid-operation discards D content and clears stall_cnt.
- Per-posedge priority is flush, then stall, then load:
  - flush = 1 (overrides stall): ir_d = NOP_WORD; valid_d = 0; bd_d = 0; exc_d = 0; pc_d, pc4_d and pc8_d load the normal load values (pc, pc+4, pc+8) so the EPC source stays current; stall_cnt unchanged.
  - stall = 1, flush = 0: all D outputs hold. stall_cnt increments if valid_d = 1 and saturates at all-ones (no wrap).
  - Otherwise (load):
    - pc_d = pc; pc4_d = pc + 4; pc8_d = pc + 8. All are XLEN-bit modulo sums, so the top of the address space wraps silently.
    - valid_d = 1.
    - bd_d = d_is_branch & valid_d, using the pre-edge value of valid_d.
    - Fetch check: if pc[1:0] != 0, or pc < IMEM_BASE, or pc >= IMEM_BASE + IMEM_SIZE, then exc_d = 4 and ir_d = NOP_WORD (instr ignored). Otherwise exc_d = 0 and ir_d = instr.
- Latency: one cycle from fetch to D outputs. No combinational path from any input to any output.
- All outputs are registers. Internally there is one next-state mux; no other state exists.

Test Plan:
- Reset then release: pc = 0x3000, instr = 0x3C01_1234, one posedge → ir_d = 0x3C01_1234, pc_d = 0x3000, pc4_d = 0x3004, pc8_d = 0x3008, valid_d = 1, exc_d = 0.
- Branch then delay slot:
  - Load a beq at 0x3000 with d_is_branch = 1.
  - Next load at 0x3004 → bd_d = 1.
  - The load after that with d_is_branch = 0 → bd_d = 0.
- Stall 3 cycles with valid_d = 1: outputs frozen, stall_cnt goes 0 → 3. With CNT_W = 2, a 5-cycle stall leaves stall_cnt = 3 (saturated).
- flush and stall asserted together with pc = 0x3010 → ir_d = 0, valid_d = 0, pc_d = 0x3010, bd_d = 0.
- Faulting fetches:
  - pc = 0x3002 → exc_d = 4, ir_d = NOP_WORD.
  - pc = 0x4000 → exc_d = 4.
  - pc = 0x3FFC → exc_d = 0.
- Asynchronous reset pulled low mid-cycle during a stall → all outputs at reset values before the next clock edge; stall_cnt = 0.
